div32x32_seq: RTL
=================

# div32x32_seq

Sequential 32-bit unsigned restoring divider, the inverse-operation companion to the team's sequential 32x32 multiplier. It accepts a dividend/divisor pair on a start pulse and produces one quotient bit per cycle. It reports completion with a one-cycle done pulse and holds the quotient and remainder until the next accepted start. It uses the same start/busy handshake as the multiplier, so one host sequencer can drive either unit.

## Interface
- WIDTH, 32, operand and result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  32  unsigned dividend; sampled with start.
- divisor  in  32  unsigned divisor; sampled with start.
- busy  out  1  high while a division is in progress (CALC state).
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- quotient  out  32  result register; held until the next accepted start.
- remainder  out  32  result register; held until the next accepted start.
- div_by_zero  out  1  set with done when divisor was 0; held with the results.

## Operation
- States: IDLE, CALC, DONE.
- Reset (synchronous): state=IDLE. busy, done, div_by_zero, quotient and remainder are all 0. The iteration counter is 0.
- IDLE, start=1, divisor!=0:
  - Latch the dividend into the shift register, clear the partial remainder, load the iteration count.
  - Go to CALC.
- IDLE, start=1, divisor==0:
  - Go to DONE directly.
  - Results: quotient=32'hFFFFFFFF, remainder=dividend, div_by_zero=1.
- IDLE, start=0: stay in IDLE.
- CALC, each cycle:
  - r' = {r[30:0], d[31]}; d <<= 1.
  - 33-bit trial t = {1'b0,r'} - {1'b0,divisor}.
  - If t[32]==0: r=t[31:0] and the quotient bit is 1. Otherwise r=r' and the quotient bit is 0.
  - The quotient bit shifts into the quotient LSB; the counter decrements.
  - On the last iteration, write the quotient/remainder outputs and go to DONE.
- DONE: done=1, busy=0. Always returns to IDLE next cycle. A start in DONE is ignored.
- A start while in CALC or DONE is ignored. Operand changes outside the start cycle have no effect.
- div_by_zero clears when the next start is accepted with a nonzero divisor.
- The quotient/remainder outputs change only on entry to DONE or on reset. They never show intermediate values.

## Timing
- Cycle 0: start=1 in IDLE. Operands are captured at the end of cycle 0.
- Cycles 1..32: CALC, busy=1.
- Cycle 33: DONE, done=1, results valid. Latency is 33 cycles, start to done.
- Divide-by-zero: done in cycle 1, with busy=0 throughout.
- The earliest next start is cycle 34, in IDLE. Throughput is one division per 34 cycles.
- Reset mid-operation: the cycle after reset is asserted, state=IDLE and all outputs are 0. No done pulse is produced for the aborted division.
- If reset and start are both high, reset wins.

## Configuration
- DIV32_FAST_SKIP_EN defined: leading-zero-byte skip.
  - In the start cycle, k = number of leading zero bytes of dividend (0..4).
  - The dividend is preloaded shifted left by 8k; the iteration count is 32-8k.
  - Latency = 33-8k. A dividend of 0 goes to DONE in cycle 1 with quotient=0, remainder=0.
  - busy stays high only in CALC. Divide-by-zero takes precedence over the skip.
- DIV32_FAST_SKIP_EN undefined: always 32 iterations and latency 33. The skip logic is not synthesized.
- Results are bit-identical in both builds.

## Test plan
- 100/7 -> quotient=14, remainder=2, div_by_zero=0. done in cycle 33, or cycle 9 with the macro (k=3). busy high in exactly the CALC cycles.
- 32'hFFFFFFFF/1 -> quotient=32'hFFFFFFFF, remainder=0, done in cycle 33 in both builds (k=0).
- 32'h12345678/0 -> done in cycle 1, div_by_zero=1, quotient=32'hFFFFFFFF, remainder=32'h12345678. A following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- 32'hFFFFFFFE/32'hFFFFFFFF -> quotient=0, remainder=32'hFFFFFFFE. Outputs then hold across 10 idle cycles with random operands and start=0.
- A start pulse with different operands in cycle 10 (CALC) and in the DONE cycle is ignored. The original result is produced, and a start in the cycle after DONE is accepted.
- Reset asserted in cycle 15 of a division -> cycle 16: IDLE, busy=0, quotient=0, remainder=0, no done pulse. A new 0/5 gives quotient=0, remainder=0 (cycle 1 with the macro, cycle 33 without).

Source files
------------

// File: rtl/div32x32_seq_if.sv
// Start/busy handshake bundle for the sequential 32-bit divider.
// The host drives operands and start; the divider returns status and results.
interface div32x32_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div32x32_seq.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per cycle.
// Optional DIV32_FAST_SKIP_EN skips leading zero bytes of the dividend.
module div32x32_seq #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    div32x32_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] d_reg, r_reg, q_reg, divisor_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             dbz_reg;
    logic [5:0]       cnt_reg;

    logic [WIDTH-1:0] d_load;
    logic [5:0]       cnt_load;
    logic             load_zero;

`ifdef DIV32_FAST_SKIP_EN
    logic [3:0] byte_zero;
    logic [2:0] lz_bytes;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_zero
            assign byte_zero[gi] = (bus.dividend[8*gi +: 8] == 8'd0);
        end
    endgenerate

    always_comb begin
        lz_bytes = 3'd0;
        if (!byte_zero[3])      lz_bytes = 3'd0;
        else if (!byte_zero[2]) lz_bytes = 3'd1;
        else if (!byte_zero[1]) lz_bytes = 3'd2;
        else if (!byte_zero[0]) lz_bytes = 3'd3;
        else                    lz_bytes = 3'd4;
    end

    // Zero bytes shifted out up front contribute only zero quotient bits.
    assign d_load    = bus.dividend << {lz_bytes, 3'b000};
    assign cnt_load  = 6'd32 - {lz_bytes, 3'b000};
    assign load_zero = (lz_bytes == 3'd4);
`else
    assign d_load    = bus.dividend;
    assign cnt_load  = 6'd32;
    assign load_zero = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, try the subtraction.
    logic [WIDTH-1:0] r_shift, r_step, q_step;
    logic [WIDTH:0]   trial;
    logic             q_bit;

    always_comb begin
        r_shift = {r_reg[WIDTH-2:0], d_reg[WIDTH-1]};
        trial   = {1'b0, r_shift} - {1'b0, divisor_reg};
        q_bit   = ~trial[WIDTH];
        r_step  = q_bit ? trial[WIDTH-1:0] : r_shift;
        q_step  = {q_reg[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0 || load_zero) state_next = DONE;
                    else                                state_next = CALC;
                end
            end
            CALC:    if (cnt_reg == 6'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_reg         <= '0;
            r_reg         <= '0;
            q_reg         <= '0;
            divisor_reg   <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                            dbz_reg       <= 1'b1;
                        end else begin
                            dbz_reg <= 1'b0;
                            if (load_zero) begin
                                quotient_reg  <= '0;
                                remainder_reg <= '0;
                            end
                            d_reg       <= d_load;
                            r_reg       <= '0;
                            q_reg       <= '0;
                            cnt_reg     <= cnt_load;
                            divisor_reg <= bus.divisor;
                        end
                    end
                end
                CALC: begin
                    d_reg   <= d_reg << 1;
                    r_reg   <= r_step;
                    q_reg   <= q_step;
                    cnt_reg <= cnt_reg - 6'd1;
                    // Results become visible only as DONE is entered.
                    if (cnt_reg == 6'd1) begin
                        quotient_reg  <= q_step;
                        remainder_reg <= r_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_reg == CALC);
    assign bus.done        = (state_reg == DONE);
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule
